// File: rtl/gfx_pkg.sv
// Shared graphics types and constants: coordinate/address widths, pixel formats,
// and the strip coalescer state encoding.
package gfx_pkg;

  localparam int point_width         = 16;
  localparam int address_width       = 32;
  localparam int STRIP_BYTES_DEFAULT = 16;

  typedef enum logic [1:0] {
    BPP8  = 2'd0,
    BPP16 = 2'd1,
    BPP24 = 2'd2,
    BPP32 = 2'd3
  } color_depth_t;

  typedef enum logic [1:0] {
    CO_EMPTY = 2'd0,
    CO_ACCUM = 2'd1,
    CO_DRAIN = 2'd2
  } coalesce_state_t;

  // BPP24 occupies a full 4-byte slot so pixels never straddle a strip.
  function automatic logic [2:0] bytes_per_pixel(color_depth_t depth);
    case (depth)
      BPP8:    return 3'd1;
      BPP16:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/gfx_strip_coalescer_if.sv
// Pixel request and strip write buses of the strip coalescer.
interface gfx_strip_coalescer_if
  import gfx_pkg::*;
#(
  parameter int NB = STRIP_BYTES_DEFAULT
);

  logic                     pix_valid_i;
  logic                     pix_ready_o;
  logic [point_width-1:0]   pix_x_i;
  logic [point_width-1:0]   pix_y_i;
  logic [31:0]              pix_color_i;

  logic                     strip_valid_o;
  logic                     strip_ready_i;
  logic [address_width-1:0] strip_adr_o;
  logic [NB*8-1:0]          strip_dat_o;
  logic [NB-1:0]            strip_sel_o;

  // Both buses: a transfer happens on a clock edge where valid & ready are high;
  // once raised, valid and its payload hold unchanged until that transfer.
  modport master (
    output pix_valid_i, pix_x_i, pix_y_i, pix_color_i, strip_ready_i,
    input  pix_ready_o, strip_valid_o, strip_adr_o, strip_dat_o, strip_sel_o
  );

  modport slave (
    input  pix_valid_i, pix_x_i, pix_y_i, pix_color_i, strip_ready_i,
    output pix_ready_o, strip_valid_o, strip_adr_o, strip_dat_o, strip_sel_o
  );

endinterface

// File: rtl/gfx_pixel_addr.sv
// Stage A: turns (x, y, color) into a strip tag plus lane-aligned data and byte enables.
module gfx_pixel_addr
  import gfx_pkg::*;
#(
  parameter int NB = STRIP_BYTES_DEFAULT
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   pix_valid_i,
  output logic                                   pix_ready_o,
  input  logic [point_width-1:0]                 pix_x_i,
  input  logic [point_width-1:0]                 pix_y_i,
  input  logic [31:0]                            pix_color_i,
  input  color_depth_t                           depth_i,
  input  logic [address_width-1:0]               base_i,
  input  logic [15:0]                            pitch_i,
  input  logic                                   take_i,
  output logic                                   a_valid_o,
  output logic [address_width-1:$clog2(NB)]      a_tag_o,
  output logic [NB*8-1:0]                        a_dat_o,
  output logic [NB-1:0]                          a_sel_o
);

  localparam int OW = $clog2(NB);
  localparam int DW = NB * 8;

  logic [2:0]               bpp;
  logic [address_width-1:0] adr;
  logic [OW-1:0]            ofs;
  logic [31:0]              color_m;
  logic [NB-1:0]            sel_base;

  always_comb begin
    bpp      = bytes_per_pixel(depth_i);
    adr      = base_i + address_width'(pix_y_i) * address_width'(pitch_i)
             + address_width'(pix_x_i) * address_width'(bpp);
    ofs      = adr[OW-1:0];
    color_m  = pix_color_i;
    sel_base = NB'(4'hF);
    // Unused high color bytes are zeroed so BPP24 writes its pad byte as 0.
    case (depth_i)
      BPP8:    begin color_m = {24'h0, pix_color_i[7:0]};  sel_base = NB'(4'h1); end
      BPP16:   begin color_m = {16'h0, pix_color_i[15:0]}; sel_base = NB'(4'h3); end
      BPP24:   begin color_m = {8'h0, pix_color_i[23:0]};  sel_base = NB'(4'hF); end
      default: begin color_m = pix_color_i;                sel_base = NB'(4'hF); end
    endcase
  end

  assign pix_ready_o = !a_valid_o || take_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_valid_o <= 1'b0;
      a_tag_o   <= '0;
      a_dat_o   <= '0;
      a_sel_o   <= '0;
    end else if (pix_valid_i && pix_ready_o) begin
      a_valid_o <= 1'b1;
      a_tag_o   <= adr[address_width-1:OW];
      a_dat_o   <= DW'(color_m) << {ofs, 3'b000};
      a_sel_o   <= sel_base << ofs;
    end else if (take_i) begin
      a_valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/gfx_strip_coalescer.sv
// Merges consecutive pixel writes landing in one strip into a single byte-enabled strip write.
// Optional idle-timeout flush of partial strips: define GFX_COALESCE_TIMEOUT_EN.
module gfx_strip_coalescer
  import gfx_pkg::*;
#(
  parameter int STRIP_BYTES = STRIP_BYTES_DEFAULT
`ifdef GFX_COALESCE_TIMEOUT_EN
  , parameter int TIMEOUT = 64
`endif
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  gfx_strip_coalescer_if.slave     bus,
  input  color_depth_t             depth_i,
  input  logic [address_width-1:0] base_i,
  input  logic [15:0]              pitch_i,
  input  logic                     flush_i,
  output logic                     idle_o,
  output coalesce_state_t          dbg_state_o
);

  localparam int OW = $clog2(STRIP_BYTES);
  localparam int DW = STRIP_BYTES * 8;
  localparam int TW = address_width - OW;

  logic                   a_valid, a_take;
  logic [TW-1:0]          a_tag;
  logic [DW-1:0]          a_dat, a_mask;
  logic [STRIP_BYTES-1:0] a_sel;

  coalesce_state_t        state, state_nxt;
  logic [TW-1:0]          buf_tag, out_tag;
  logic [DW-1:0]          buf_dat, out_dat;
  logic [STRIP_BYTES-1:0] buf_sel, out_sel;
  logic                   out_valid, out_free, tag_hit;
  logic                   flush_pend, flush_any, to_fire;
  logic                   load_buf, merge, move_out;

  gfx_pixel_addr #(.NB(STRIP_BYTES)) u_pixel_addr (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .pix_valid_i (bus.pix_valid_i),
    .pix_ready_o (bus.pix_ready_o),
    .pix_x_i     (bus.pix_x_i),
    .pix_y_i     (bus.pix_y_i),
    .pix_color_i (bus.pix_color_i),
    .depth_i     (depth_i),
    .base_i      (base_i),
    .pitch_i     (pitch_i),
    .take_i      (a_take),
    .a_valid_o   (a_valid),
    .a_tag_o     (a_tag),
    .a_dat_o     (a_dat),
    .a_sel_o     (a_sel)
  );

  assign out_free  = !out_valid || bus.strip_ready_i;
  assign tag_hit   = (a_tag == buf_tag);
  assign flush_any = flush_pend || flush_i;
  assign idle_o    = !a_valid && (state == CO_EMPTY) && !out_valid;

  always_comb begin
    a_mask = '0;
    for (int i = 0; i < STRIP_BYTES; i++) a_mask[i*8 +: 8] = {8{a_sel[i]}};
  end

  always_comb begin
    state_nxt = state;
    a_take    = 1'b0;
    load_buf  = 1'b0;
    merge     = 1'b0;
    move_out  = 1'b0;
    case (state)
      CO_EMPTY: begin
        if (a_valid) begin
          a_take    = 1'b1;
          load_buf  = 1'b1;
          state_nxt = CO_ACCUM;
        end
      end
      CO_ACCUM: begin
        if (a_valid) begin
          if (tag_hit) begin
            a_take = 1'b1;
            merge  = 1'b1;
          end else if (out_free) begin
            a_take   = 1'b1;
            move_out = 1'b1;
            load_buf = 1'b1;
          end
        end else if (flush_any) begin
          // Drain straight away when the output is free; CO_DRAIN only waits it out.
          if (out_free) begin
            move_out  = 1'b1;
            state_nxt = CO_EMPTY;
          end else begin
            state_nxt = CO_DRAIN;
          end
        end
      end
      CO_DRAIN: begin
        if (out_free) begin
          move_out  = 1'b1;
          state_nxt = CO_EMPTY;
        end
      end
      default: state_nxt = CO_EMPTY;
    endcase
  end

`ifdef GFX_COALESCE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] to_cnt;
  logic          to_run;

  assign to_run  = (state == CO_ACCUM) && !a_valid && !flush_pend;
  assign to_fire = to_run && (to_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                       to_cnt <= '0;
    else if (!to_run || merge || to_fire) to_cnt <= '0;
    else                               to_cnt <= to_cnt + 1'b1;
  end
`else
  assign to_fire = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= CO_EMPTY;
      flush_pend <= 1'b0;
      buf_tag    <= '0;
      buf_dat    <= '0;
      buf_sel    <= '0;
      out_valid  <= 1'b0;
      out_tag    <= '0;
      out_dat    <= '0;
      out_sel    <= '0;
    end else begin
      state <= state_nxt;
      if (flush_i || to_fire) flush_pend <= 1'b1;
      else if (idle_o)        flush_pend <= 1'b0;

      if (load_buf) begin
        buf_tag <= a_tag;
        buf_dat <= a_dat;
        buf_sel <= a_sel;
      end else if (merge) begin
        buf_dat <= (buf_dat & ~a_mask) | (a_dat & a_mask);
        buf_sel <= buf_sel | a_sel;
      end

      if (move_out) begin
        out_valid <= 1'b1;
        out_tag   <= buf_tag;
        out_dat   <= buf_dat;
        out_sel   <= buf_sel;
      end else if (bus.strip_ready_i) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.strip_valid_o = out_valid;
  assign bus.strip_adr_o   = {out_tag, {OW{1'b0}}};
  assign bus.strip_dat_o   = out_dat;
  assign bus.strip_sel_o   = out_sel;
  assign dbg_state_o       = state;

endmodule

// File: tb/tb_gfx_strip_coalescer.sv
// Directed bench for gfx_strip_coalescer: spans, lane placement, backpressure, flush timing, reset.
module tb_gfx_strip_coalescer;
  import gfx_pkg::*;

  localparam int SB = 16;
  localparam int DW = SB * 8;

  logic            clk = 1'b0;
  logic            rst_n;
  color_depth_t    depth;
  logic [31:0]     base;
  logic [15:0]     pitch;
  logic            flush;
  logic            idle;
  coalesce_state_t dbg_state;

  int errors = 0;
  int checks = 0;

  logic [31:0]   got_adr_q[$];
  logic [DW-1:0] got_dat_q[$];
  logic [SB-1:0] got_sel_q[$];
  logic [31:0]   exp_q[$];

  gfx_strip_coalescer_if #(.NB(SB)) bus();

  gfx_strip_coalescer #(
`ifdef GFX_COALESCE_TIMEOUT_EN
    .TIMEOUT(8),
`endif
    .STRIP_BYTES(SB)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (bus),
    .depth_i     (depth),
    .base_i      (base),
    .pitch_i     (pitch),
    .flush_i     (flush),
    .idle_o      (idle),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // capture every accepted strip
  always @(negedge clk) begin
    if (rst_n && bus.strip_valid_o && bus.strip_ready_i) begin
      got_adr_q.push_back(bus.strip_adr_o);
      got_dat_q.push_back(bus.strip_dat_o);
      got_sel_q.push_back(bus.strip_sel_o);
    end
  end

  // driver tasks
  task automatic clear_got();
    got_adr_q.delete();
    got_dat_q.delete();
    got_sel_q.delete();
  endtask

  task automatic setup(input color_depth_t d, input logic [31:0] b, input logic [15:0] p);
    depth = d;
    base  = b;
    pitch = p;
    clear_got();
  endtask

  task automatic send_pixel(input int x, input int y, input logic [31:0] c);
    bit ok = 1'b0;
    bus.pix_x_i     = 16'(x);
    bus.pix_y_i     = 16'(y);
    bus.pix_color_i = c;
    bus.pix_valid_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.pix_ready_o) begin ok = 1'b1; break; end
    end
    @(posedge clk);
    #1;
    bus.pix_valid_i = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL pix_accept: x=%0d no ready within 200 cycles", x); end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic wait_strips(input int n);
    for (int i = 0; i < 200; i++) begin
      if (got_adr_q.size() >= n) break;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (idle) break;
    end
    @(posedge clk);
    #1;
  endtask

  // tests
  task automatic test_reset();
    rst_n = 1'b0;
    bus.pix_valid_i = 1'b0; bus.pix_x_i = '0; bus.pix_y_i = '0; bus.pix_color_i = '0;
    bus.strip_ready_i = 1'b1;
    flush = 1'b0; depth = BPP8; base = '0; pitch = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.strip_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", bus.strip_valid_o); end
    checks++; if (bus.strip_adr_o !== 32'h0) begin errors++; $display("FAIL reset_adr: got %h exp 0", bus.strip_adr_o); end
    checks++; if (bus.strip_dat_o !== '0) begin errors++; $display("FAIL reset_dat: got %h exp 0", bus.strip_dat_o); end
    checks++; if (bus.strip_sel_o !== 16'h0) begin errors++; $display("FAIL reset_sel: got %h exp 0", bus.strip_sel_o); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b exp 1", idle); end
    checks++; if (bus.pix_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", bus.pix_ready_o); end
    checks++; if (dbg_state !== CO_EMPTY) begin errors++; $display("FAIL reset_state: got %0d exp %0d", dbg_state, CO_EMPTY); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_bpp8_span();
    logic [DW-1:0] exp_dat;
    setup(BPP8, 32'h1000, 16'd640);
    for (int i = 0; i < 16; i++) begin
      exp_dat[i*8 +: 8] = 8'(16 + i);
      send_pixel(i, 0, {24'hABCDEF, 8'(16 + i)});
    end
    pulse_flush();
    wait_strips(1);
    wait_idle();
    checks++; if (got_adr_q.size() != 1) begin errors++; $display("FAIL span_count: got %0d exp 1", got_adr_q.size()); end
    if (got_adr_q.size() > 0) begin
      checks++; if (got_adr_q[0] !== 32'h1000) begin errors++; $display("FAIL span_adr: got %h exp 00001000", got_adr_q[0]); end
      checks++; if (got_sel_q[0] !== 16'hFFFF) begin errors++; $display("FAIL span_sel: got %h exp ffff", got_sel_q[0]); end
      checks++; if (got_dat_q[0] !== exp_dat) begin errors++; $display("FAIL span_dat: got %h exp %h", got_dat_q[0], exp_dat); end
    end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL span_idle: got %b exp 1", idle); end
  endtask

  task automatic test_bpp32_split();
    setup(BPP32, 32'h2000, 16'd640);
    send_pixel(3, 0, 32'hAABBCCDD);
    send_pixel(4, 0, 32'h11223344);
    pulse_flush();
    wait_strips(2);
    wait_idle();
    checks++; if (got_adr_q.size() != 2) begin errors++; $display("FAIL split_count: got %0d exp 2", got_adr_q.size()); end
    if (got_adr_q.size() >= 2) begin
      checks++; if (got_adr_q[0] !== 32'h2000) begin errors++; $display("FAIL split_adr0: got %h exp 00002000", got_adr_q[0]); end
      checks++; if (got_sel_q[0] !== 16'hF000) begin errors++; $display("FAIL split_sel0: got %h exp f000", got_sel_q[0]); end
      checks++; if (got_dat_q[0] !== 128'hAABBCCDD_00000000_00000000_00000000) begin errors++; $display("FAIL split_dat0: got %h", got_dat_q[0]); end
      checks++; if (got_adr_q[1] !== 32'h2010) begin errors++; $display("FAIL split_adr1: got %h exp 00002010", got_adr_q[1]); end
      checks++; if (got_sel_q[1] !== 16'h000F) begin errors++; $display("FAIL split_sel1: got %h exp 000f", got_sel_q[1]); end
      checks++; if (got_dat_q[1] !== 128'h11223344) begin errors++; $display("FAIL split_dat1: got %h", got_dat_q[1]); end
    end
  endtask

  task automatic test_bpp16_overwrite();
    // y=1, x=2: 0x3000 + 640 + 4 = 0x3284 -> strip 0x3280, lanes 4..5
    setup(BPP16, 32'h3000, 16'd640);
    send_pixel(2, 1, 32'hFFFF1111);
    send_pixel(2, 1, 32'h00002222);
    pulse_flush();
    wait_strips(1);
    wait_idle();
    checks++; if (got_adr_q.size() != 1) begin errors++; $display("FAIL ovw_count: got %0d exp 1", got_adr_q.size()); end
    if (got_adr_q.size() > 0) begin
      checks++; if (got_adr_q[0] !== 32'h3280) begin errors++; $display("FAIL ovw_adr: got %h exp 00003280", got_adr_q[0]); end
      checks++; if (got_sel_q[0] !== 16'h0030) begin errors++; $display("FAIL ovw_sel: got %h exp 0030", got_sel_q[0]); end
      checks++; if (got_dat_q[0] !== 128'h2222_00000000) begin errors++; $display("FAIL ovw_dat: got %h", got_dat_q[0]); end
    end
  endtask

  task automatic test_bpp24_pad();
    setup(BPP24, 32'h4000, 16'd640);
    send_pixel(1, 0, 32'hEE123456);
    pulse_flush();
    wait_strips(1);
    wait_idle();
    checks++; if (got_adr_q.size() != 1) begin errors++; $display("FAIL bpp24_count: got %0d exp 1", got_adr_q.size()); end
    if (got_adr_q.size() > 0) begin
      checks++; if (got_sel_q[0] !== 16'h00F0) begin errors++; $display("FAIL bpp24_sel: got %h exp 00f0", got_sel_q[0]); end
      checks++; if (got_dat_q[0] !== 128'h00123456_00000000) begin errors++; $display("FAIL bpp24_dat: got %h", got_dat_q[0]); end
    end
  endtask

  task automatic test_flush_timing();
    // y=2, x=5: 0x5000 + 1280 + 20 = 0x5514 -> strip 0x5510, lanes 4..7
    setup(BPP32, 32'h5000, 16'd640);
    bus.pix_x_i = 16'd5; bus.pix_y_i = 16'd2; bus.pix_color_i = 32'hCAFEF00D;
    bus.pix_valid_i = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    bus.pix_valid_i = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.strip_valid_o !== 1'b0) begin errors++; $display("FAIL flush_early: got %b exp 0 after N+1", bus.strip_valid_o); end
    @(negedge clk);
    checks++; if (bus.strip_valid_o !== 1'b1) begin errors++; $display("FAIL flush_latency: got %b exp 1 after N+2", bus.strip_valid_o); end
    wait_idle();
    checks++; if (got_adr_q.size() != 1) begin errors++; $display("FAIL flush_count: got %0d exp 1", got_adr_q.size()); end
    if (got_adr_q.size() > 0) begin
      checks++; if (got_adr_q[0] !== 32'h5510) begin errors++; $display("FAIL flush_adr: got %h exp 00005510", got_adr_q[0]); end
      checks++; if (got_dat_q[0] !== 128'hCAFEF00D_00000000) begin errors++; $display("FAIL flush_dat: got %h", got_dat_q[0]); end
    end
  endtask

  task automatic test_back_to_back();
    logic ready_seen_low = 1'b0;
    setup(BPP32, 32'h0100, 16'd640);
    exp_q.delete();
    exp_q.push_back(32'h0100);
    exp_q.push_back(32'h0110);
    exp_q.push_back(32'h0120);
    bus.strip_ready_i = 1'b0;
    send_pixel(0, 0, 32'h000000A0);
    send_pixel(4, 0, 32'h000000A4);
    send_pixel(8, 0, 32'h000000A8);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (!bus.pix_ready_o) ready_seen_low = 1'b1;
    end
    checks++; if (ready_seen_low !== 1'b1) begin errors++; $display("FAIL bp_ready_drop: got %b exp 1", ready_seen_low); end
    checks++; if (bus.pix_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready_hold: got %b exp 0", bus.pix_ready_o); end
    checks++; if (bus.strip_valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid_hold: got %b exp 1", bus.strip_valid_o); end
    checks++; if (bus.strip_adr_o !== 32'h0100) begin errors++; $display("FAIL bp_adr_stable: got %h exp 00000100", bus.strip_adr_o); end
    @(posedge clk);
    #1;
    bus.strip_ready_i = 1'b1;
    pulse_flush();
    wait_strips(3);
    wait_idle();
    checks++; if (got_adr_q.size() != 3) begin errors++; $display("FAIL bp_count: got %0d exp 3", got_adr_q.size()); end
    for (int i = 0; i < 3 && i < got_adr_q.size(); i++) begin
      checks++; if (got_adr_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_order%0d: got %h exp %h", i, got_adr_q[i], exp_q[i]); end
      checks++; if (got_sel_q[i] !== 16'h000F) begin errors++; $display("FAIL bp_sel%0d: got %h exp 000f", i, got_sel_q[i]); end
      checks++; if (got_dat_q[i] !== DW'(32'hA0 + 4 * i)) begin errors++; $display("FAIL bp_dat%0d: got %h exp %h", i, got_dat_q[i], DW'(32'hA0 + 4 * i)); end
    end
  endtask

`ifdef GFX_COALESCE_TIMEOUT_EN
  task automatic test_timeout();
    int wait_cycles = 0;
    bit seen = 1'b0;
    setup(BPP8, 32'h0000, 16'd640);
    send_pixel(1, 0, 32'h00000055);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      wait_cycles++;
      if (bus.strip_valid_o) begin seen = 1'b1; break; end
    end
    checks++; if (!seen || wait_cycles < 8 || wait_cycles > 14) begin errors++; $display("FAIL timeout_emit: seen=%b after %0d cycles exp about 10", seen, wait_cycles); end
    wait_idle();
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL timeout_idle: got %b exp 1", idle); end
    checks++; if (got_sel_q.size() != 1 || got_sel_q[0] !== 16'h0002) begin errors++; $display("FAIL timeout_strip: count %0d exp 1 with sel 0002", got_sel_q.size()); end
  endtask
`else
  task automatic test_no_timeout();
    setup(BPP8, 32'h0000, 16'd640);
    send_pixel(1, 0, 32'h00000055);
    repeat (100) @(negedge clk);
    checks++; if (got_adr_q.size() != 0) begin errors++; $display("FAIL no_timeout_emit: got %0d strips exp 0", got_adr_q.size()); end
    checks++; if (dbg_state !== CO_ACCUM) begin errors++; $display("FAIL no_timeout_state: got %0d exp %0d", dbg_state, CO_ACCUM); end
    @(posedge clk);
    #1;
    pulse_flush();
    wait_strips(1);
    wait_idle();
    checks++; if (got_sel_q.size() != 1 || got_sel_q[0] !== 16'h0002) begin errors++; $display("FAIL no_timeout_flush: count %0d exp 1 with sel 0002", got_sel_q.size()); end
  endtask
`endif

  task automatic test_reset_mid();
    setup(BPP32, 32'h0000, 16'd640);
    bus.strip_ready_i = 1'b0;
    send_pixel(0, 0, 32'h00000001);
    send_pixel(4, 0, 32'h00000002);
    send_pixel(5, 0, 32'h00000003);
    repeat (2) @(negedge clk);
    checks++; if (bus.strip_valid_o !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid: got %b exp 1", bus.strip_valid_o); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.strip_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b exp 0", bus.strip_valid_o); end
    checks++; if (bus.strip_adr_o !== 32'h0) begin errors++; $display("FAIL rstmid_adr: got %h exp 0", bus.strip_adr_o); end
    checks++; if (bus.strip_dat_o !== '0) begin errors++; $display("FAIL rstmid_dat: got %h exp 0", bus.strip_dat_o); end
    checks++; if (bus.strip_sel_o !== 16'h0) begin errors++; $display("FAIL rstmid_sel: got %h exp 0", bus.strip_sel_o); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rstmid_idle: got %b exp 1", idle); end
    checks++; if (bus.pix_ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b exp 1", bus.pix_ready_o); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.strip_ready_i = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (got_adr_q.size() != 0) begin errors++; $display("FAIL rstmid_no_strip: got %0d strips exp 0", got_adr_q.size()); end
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_bpp8_span();
    test_bpp32_split();
    test_bpp16_overwrite();
    test_bpp24_pad();
    test_flush_timing();
    test_back_to_back();
`ifdef GFX_COALESCE_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
